pport_nibble_rx: RTL and testbench

PPORT_NIBBLE_RX -- requirements
Module: pport_nibble_rx

---
 rtl/gb_pkg.sv | 18 +
 rtl/pport_fifo.sv | 78 +++++++
 rtl/pport_nibble_rx.sv | 182 ++++++++++++++++++
 tb/tb_pport_nibble_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the parallel-port nibble receiver: assembler
// state encoding, default FIFO depth and the status-word bit layout
// used by the 1E40_0000 register decoder.
package gb_pkg;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } asm_state_t;

  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam logic [31:0] STATUS_ADDR       = 32'h1E40_0000;
  localparam int unsigned STAT_RD_VALID_BIT = 0;
  localparam int unsigned STAT_OVERFLOW_BIT = 1;
  localparam int unsigned STAT_TIMEOUT_BIT  = 2;

endpackage

// File: rtl/pport_fifo.sv
// First-word-fall-through FIFO with a registered head stage.
// Entries land in the memory array first and are moved into the head
// register on the following edge, so rd_valid/rd_data are always flop
// outputs. count is total occupancy (memory plus head).
module pport_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head_q;
  logic             head_v;

  logic pop_ok;
  logic push_ok;
  logic load;

  // Handshake qualification: pops need a valid head, pushes need room
  // unless a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok  = pop & head_v;
    full    = (cnt == CW'(DEPTH));
    empty   = ~head_v;
    push_ok = push & (~full | pop_ok);
    load    = (mem_cnt != '0) & (~head_v | pop_ok);
  end

  // Storage array; contents need no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy counters and the registered head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      cnt     <= '0;
      head_q  <= '0;
      head_v  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + CW'(push_ok) - CW'(load);
      cnt     <= cnt + CW'(push_ok) - CW'(pop_ok);
      if (load) begin
        head_q <= mem[rd_ptr];
        head_v <= 1'b1;
      end else if (pop_ok) begin
        head_v <= 1'b0;
      end
    end
  end

  assign rd_data  = head_q;
  assign rd_valid = head_v;
  assign count    = cnt;

endmodule

// File: rtl/pport_nibble_rx.sv
// Parallel-port nibble receiver: synchronizes the remote nibble bus and
// strobe, assembles {high, low} nibble pairs into bytes and queues them
// in a FWFT FIFO for the bus decoder.
// Optional feature: define PPORT_RX_TIMEOUT_EN to abandon a pending low
// nibble after TIMEOUT_CYCLES clocks and flag it on timeout.
module pport_nibble_rx
  import gb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic                          clk,
  input  logic                          cold_reset,
  input  logic [3:0]                    remote_d,
  input  logic                          remote_data_ready,
  output logic                          remote_ack,
  input  logic                          rd_pop,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout,
  input  logic                          clr_flags
);

  logic [3:0]             d_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                   edge_q;
  logic                   armed;
  logic [2:0]             fill_cnt;
  logic                   rise;
  logic [3:0]             d_last;

  asm_state_t state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] byte_q, byte_d;
  logic       push_q, push_d;
  logic       ack_q, ack_d;
  logic       tmo_hit;
  logic       tmo_evt;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_req;
  logic       ovf_q;

  // Synchronizer chains for the nibble bus and the strobe.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '0;
      stb_sync <= '0;
    end else begin
      d_sync[0] <= remote_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], remote_data_ready};
    end
  end

  // Edge-detect register; detection stays disarmed until the chain has
  // refilled after reset so a strobe already high is not seen as an edge.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) begin
      edge_q   <= 1'b0;
      armed    <= 1'b0;
      fill_cnt <= '0;
    end else begin
      edge_q <= stb_sync[SYNC_STAGES-1];
      if (!armed) begin
        if (fill_cnt == 3'(SYNC_STAGES)) armed <= 1'b1;
        else                             fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  assign rise   = armed & stb_sync[SYNC_STAGES-1] & ~edge_q;
  assign d_last = d_sync[SYNC_STAGES-1];

`ifdef PPORT_RX_TIMEOUT_EN
  logic [19:0] tcnt;

  // Cycles spent waiting for the high nibble; reloaded on every capture.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset)                   tcnt <= '0;
    else if (state_q == ST_HI && !rise) tcnt <= tcnt + 1'b1;
    else                              tcnt <= '0;
  end

  assign tmo_hit = (state_q == ST_HI) && (tcnt == TIMEOUT_CYCLES - 20'd1);

  logic tmo_q;

  // Sticky timeout flag; a coincident set beats the clear.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset)     tmo_q <= 1'b0;
    else if (tmo_evt)   tmo_q <= 1'b1;
    else if (clr_flags) tmo_q <= 1'b0;
  end

  assign timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // Assembler next state: low nibble first, byte issued on the high one.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    byte_d  = byte_q;
    push_d  = 1'b0;
    ack_d   = ack_q;
    tmo_evt = 1'b0;
    case (state_q)
      ST_LO: begin
        if (rise) begin
          lo_d    = d_last;
          ack_d   = ~ack_q;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (rise) begin
          byte_d  = {d_last, lo_q};
          push_d  = 1'b1;
          ack_d   = ~ack_q;
          state_d = ST_LO;
        end else if (tmo_hit) begin
          tmo_evt = 1'b1;
          state_d = ST_LO;
        end
      end
      default: state_d = ST_LO;
    endcase
  end

  // Assembler registers; the byte is pushed the cycle after HI capture.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) begin
      state_q <= ST_LO;
      lo_q    <= '0;
      byte_q  <= '0;
      push_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      byte_q  <= byte_d;
      push_q  <= push_d;
      ack_q   <= ack_d;
    end
  end

  assign pop_req = rd_pop & ~fifo_empty;

  // Sticky overflow: a push found the FIFO full with no pop to make room.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset)                           ovf_q <= 1'b0;
    else if (push_q && fifo_full && !pop_req) ovf_q <= 1'b1;
    else if (clr_flags)                       ovf_q <= 1'b0;
  end

  pport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (cold_reset),
    .push     (push_q),
    .wr_data  (byte_q),
    .pop      (pop_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign remote_ack = ack_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pport_nibble_rx.sv
// Self-checking bench for pport_nibble_rx (depth 4, two sync stages,
// TIMEOUT_CYCLES 100). Bytes are queued as expected results when their
// high nibble is sent and compared when popped from the DUT.
module tb_pport_nibble_rx;

  logic       clk = 1'b0;
  logic       cold_reset;
  logic [3:0] remote_d;
  logic       remote_data_ready;
  logic       remote_ack;
  logic       rd_pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;
  logic       clr_flags;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  pport_nibble_rx #(
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .clk               (clk),
    .cold_reset        (cold_reset),
    .remote_d          (remote_d),
    .remote_data_ready (remote_data_ready),
    .remote_ack        (remote_ack),
    .rd_pop            (rd_pop),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .fifo_count        (fifo_count),
    .overflow          (overflow),
    .timeout           (timeout),
    .clr_flags         (clr_flags)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    remote_d = n;
    @(negedge clk);
    remote_data_ready = 1'b1;
    repeat (4) @(negedge clk);
    remote_data_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [3:0] lo, input logic [3:0] hi);
    send_nib(lo);
    send_nib(hi);
  endtask

  task automatic do_pop();
    logic [7:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL pop_scoreboard_empty: got %0h want none", rd_data);
    end else begin
      e = sb.pop_front();
      chk("pop_valid", 32'(rd_valid), 32'd1);
      chk("pop_data", 32'(rd_data), 32'(e));
    end
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cold_reset = 1'b1;
    repeat (2) @(negedge clk);
    cold_reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Sends a low nibble, then the high nibble by hand and stops right
  // after the capture edge so the caller can act on the push edge.
  task automatic send_to_push_edge(input logic [3:0] lo, input logic [3:0] hi);
    send_nib(lo);
    remote_d = hi;
    @(negedge clk);
    remote_data_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lo: 4'h5, hi: 4'hA, exp: 8'hA5};
    vecs[1] = '{lo: 4'h0, hi: 4'h0, exp: 8'h00};
    vecs[2] = '{lo: 4'hF, hi: 4'hF, exp: 8'hFF};
    vecs[3] = '{lo: 4'hC, hi: 4'h3, exp: 8'h3C};

    cold_reset        = 1'b1;
    remote_d          = '0;
    remote_data_ready = 1'b0;
    rd_pop            = 1'b0;
    clr_flags         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ack", 32'(remote_ack), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    cold_reset = 1'b0;
    repeat (8) @(negedge clk);

    // 5 then A, with the rd_valid edge counted from strobe presentation
    send_nib(4'h5);
    chk("ack_after_lo", 32'(remote_ack), 32'd1);
    remote_d = 4'hA;
    @(negedge clk);
    remote_data_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) chk("valid_edge4", 32'(rd_valid), 32'd0);
      if (k == 5) chk("valid_edge5", 32'(rd_valid), 32'd1);
    end
    remote_data_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("ack_after_hi", 32'(remote_ack), 32'd0);
    sb.push_back(8'hA5);
    do_pop();
    chk("empty_after_a5", 32'(rd_valid), 32'd0);

    // table of byte patterns
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].lo, vecs[i].hi);
      sb.push_back(vecs[i].exp);
      chk("vec_count", 32'(fifo_count), 32'd1);
      do_pop();
      chk("vec_empty", 32'(rd_valid), 32'd0);
    end

    // six bytes into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] n;
      n = 4'(i);
      send_byte(n, 4'h0);
      if (i <= 4) sb.push_back({4'h0, n});
    end
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) do_pop();
    chk("ovf_drained", 32'(rd_valid), 32'd0);

    // full FIFO, push coincident with pop
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] n;
      n = 4'(i);
      send_byte(n, 4'h1);
      sb.push_back({4'h1, n});
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    send_to_push_edge(4'h5, 4'h1);
    chk("coinc_head", 32'(rd_data), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(8'h15);
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
    remote_data_ready = 1'b0;
    chk("coinc_count", 32'(fifo_count), 32'd4);
    chk("coinc_overflow", 32'(overflow), 32'd0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) do_pop();
    chk("coinc_drained", 32'(rd_valid), 32'd0);

    // pop on empty, then clear coincident with an overflow event
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
    @(negedge clk);
    chk("empty_pop_count", 32'(fifo_count), 32'd0);
    chk("empty_pop_valid", 32'(rd_valid), 32'd0);
    chk("empty_pop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] n;
      n = 4'(i);
      send_byte(n, 4'h2);
      sb.push_back({4'h2, n});
    end
    send_to_push_edge(4'h5, 4'h2);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    remote_data_ready = 1'b0;
    chk("clr_vs_set_ovf", 32'(overflow), 32'd1);
    chk("clr_vs_set_count", 32'(fifo_count), 32'd4);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) do_pop();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;

    // long gap between the nibbles
    send_nib(4'h3);
    repeat (150) @(negedge clk);
    send_byte(4'h7, 4'h2);
`ifdef PPORT_RX_TIMEOUT_EN
    sb.push_back(8'h27);
    chk("tmo_flag", 32'(timeout), 32'd1);
`else
    sb.push_back(8'h73);
    chk("tmo_flag", 32'(timeout), 32'd0);
`endif
    chk("tmo_count", 32'(fifo_count), 32'd1);
    do_pop();
    chk("tmo_drained", 32'(rd_valid), 32'd0);

    // reset while a low nibble is pending
    do_reset();
    send_nib(4'hF);
    chk("pre_rst_ack", 32'(remote_ack), 32'd1);
    @(negedge clk);
    cold_reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(remote_ack), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'h00);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_tmo", 32'(timeout), 32'd0);
    repeat (2) @(negedge clk);
    cold_reset = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(4'h1, 4'h2);
    sb.push_back(8'h21);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    do_pop();
    chk("post_rst_empty", 32'(rd_valid), 32'd0);

    // strobe already high when reset releases
    remote_data_ready = 1'b1;
    do_reset();
    chk("held_strobe_ack", 32'(remote_ack), 32'd0);
    remote_data_ready = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(4'h4, 4'h6);
    sb.push_back(8'h64);
    chk("held_strobe_ack2", 32'(remote_ack), 32'd0);
    chk("held_strobe_count", 32'(fifo_count), 32'd1);
    do_pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
